// File: rtl/rs_add_station.sv
// Add/sub reservation station: buffers issued ops, resolves ROB-tag operands from the CDB, dispatches ready ops.
// Optional build macro RS_AGE_ORDER_EN: oldest-ready dispatch; otherwise lowest-index-ready dispatch.
module rs_add_station #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int FUNC_W = 4
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       iss_valid,
  output logic                       iss_ready,
  input  logic                       iss_rs1b,
  input  logic [DATA_W-1:0]          iss_rs1,
  input  logic                       iss_rs2b,
  input  logic [DATA_W-1:0]          iss_rs2,
  input  logic [TAG_W-1:0]           iss_rob_ind,
  input  logic [FUNC_W-1:0]          iss_func,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [DATA_W-1:0]          disp_a,
  output logic [DATA_W-1:0]          disp_b,
  output logic [FUNC_W-1:0]          disp_func,
  output logic [TAG_W-1:0]           disp_rob_ind,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic                       func_err
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0]  DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [FUNC_W-1:0] FUNC_ADD = FUNC_W'(0);
  localparam logic [FUNC_W-1:0] FUNC_SUB = FUNC_W'(1);

  // Entry state: control bits carry reset, operand payloads do not.
  logic [DEPTH-1:0]  ent_vld;
  logic [DEPTH-1:0]  ent_rdy1;
  logic [DEPTH-1:0]  ent_rdy2;
  logic [DEPTH-1:0]  ent_disp_ok;
  logic [DATA_W-1:0] ent_op1  [DEPTH];
  logic [DATA_W-1:0] ent_op2  [DEPTH];
  logic [FUNC_W-1:0] ent_func [DEPTH];
  logic [TAG_W-1:0]  ent_rob  [DEPTH];
`ifdef RS_AGE_ORDER_EN
  logic [OCC_W-1:0]  ent_age  [DEPTH];
  logic [OCC_W-1:0]  best_age;
`endif

  logic [OCC_W-1:0]  occ_p1;
  logic              func_err_p1;
  logic              sel_lock_p1;
  logic [IDX_W-1:0]  sel_idx_p1;

  logic              func_ok;
  logic              accept;
  logic              dispatch;
  logic [IDX_W-1:0]  free_idx;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              in1_rdy;
  logic              in2_rdy;
  logic [DATA_W-1:0] in1_val;
  logic [DATA_W-1:0] in2_val;
  logic [DEPTH-1:0]  snoop1;
  logic [DEPTH-1:0]  snoop2;

  assign func_ok   = (iss_func == FUNC_ADD) || (iss_func == FUNC_SUB);
  assign iss_ready = (occ_p1 < DEPTH_C);
  assign accept    = iss_valid & iss_ready & func_ok & ~flush;
  assign dispatch  = pick_found & disp_ready;
  assign occ       = occ_p1;
  assign func_err  = func_err_p1;

  // Incoming operands: a tag being broadcast this very cycle is captured as a value.
  always_comb begin
    in1_rdy = iss_rs1b;
    in1_val = iss_rs1;
    if (!iss_rs1b && cdb_valid && (cdb_tag == iss_rs1[TAG_W-1:0])) begin
      in1_rdy = 1'b1;
      in1_val = cdb_data;
    end
    in2_rdy = iss_rs2b;
    in2_val = iss_rs2;
    if (!iss_rs2b && cdb_valid && (cdb_tag == iss_rs2[TAG_W-1:0])) begin
      in2_rdy = 1'b1;
      in2_val = cdb_data;
    end
  end

  always_comb begin
    snoop1      = '0;
    snoop2      = '0;
    ent_disp_ok = '0;
    free_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      snoop1[i] = cdb_valid & ent_vld[i] & ~ent_rdy1[i] & (ent_op1[i][TAG_W-1:0] == cdb_tag);
      snoop2[i] = cdb_valid & ent_vld[i] & ~ent_rdy2[i] & (ent_op2[i][TAG_W-1:0] == cdb_tag);
      ent_disp_ok[i] = ent_vld[i] & ent_rdy1[i] & ent_rdy2[i];
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_vld[i]) free_idx = IDX_W'(i);
    end
  end

  // Dispatch select works from registered state only; a stalled offer stays locked.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
`ifdef RS_AGE_ORDER_EN
    best_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_disp_ok[i] && (!pick_found || (ent_age[i] < best_age))) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
        best_age   = ent_age[i];
      end
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_disp_ok[i]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
`endif
    if (sel_lock_p1) begin
      pick_found = ent_disp_ok[sel_idx_p1];
      pick_idx   = sel_idx_p1;
    end
  end

  always_comb begin
    disp_valid   = pick_found;
    disp_a       = '0;
    disp_b       = '0;
    disp_func    = '0;
    disp_rob_ind = '0;
    if (pick_found) begin
      disp_a       = ent_op1[pick_idx];
      disp_b       = ent_op2[pick_idx];
      disp_func    = ent_func[pick_idx];
      disp_rob_ind = ent_rob[pick_idx];
    end
  end

  // Control state boundary: validity, readiness, ages, occupancy, lock, error pulse.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      ent_vld     <= '0;
      ent_rdy1    <= '0;
      ent_rdy2    <= '0;
      occ_p1      <= '0;
      func_err_p1 <= 1'b0;
      sel_lock_p1 <= 1'b0;
      sel_idx_p1  <= '0;
`ifdef RS_AGE_ORDER_EN
      for (int i = 0; i < DEPTH; i++) ent_age[i] <= '0;
`endif
    end else begin
      func_err_p1 <= iss_valid & iss_ready & ~func_ok;
      if (flush) begin
        ent_vld     <= '0;
        occ_p1      <= '0;
        sel_lock_p1 <= 1'b0;
      end else begin
        ent_rdy1 <= ent_rdy1 | snoop1;
        ent_rdy2 <= ent_rdy2 | snoop2;
`ifdef RS_AGE_ORDER_EN
        for (int i = 0; i < DEPTH; i++) begin
          if (dispatch && ent_vld[i] && (ent_age[i] > ent_age[pick_idx]))
            ent_age[i] <= ent_age[i] - 1'b1;
        end
`endif
        if (dispatch) ent_vld[pick_idx] <= 1'b0;
        if (accept) begin
          ent_vld[free_idx]  <= 1'b1;
          ent_rdy1[free_idx] <= in1_rdy;
          ent_rdy2[free_idx] <= in2_rdy;
`ifdef RS_AGE_ORDER_EN
          ent_age[free_idx]  <= occ_p1 - OCC_W'(dispatch);
`endif
        end
        occ_p1      <= occ_p1 + OCC_W'(accept) - OCC_W'(dispatch);
        sel_lock_p1 <= pick_found & ~disp_ready;
        sel_idx_p1  <= pick_idx;
      end
    end
  end

  // Payload boundary: operand values/tags, opcode and destination index.
  always_ff @(posedge clk1) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (snoop1[i]) ent_op1[i] <= cdb_data;
      if (snoop2[i]) ent_op2[i] <= cdb_data;
    end
    if (accept) begin
      ent_op1[free_idx]  <= in1_val;
      ent_op2[free_idx]  <= in2_val;
      ent_func[free_idx] <= iss_func;
      ent_rob[free_idx]  <= iss_rob_ind;
    end
  end

endmodule

// File: tb/tb_rs_add_station.sv
// Directed bench for rs_add_station with a dispatch scoreboard queue.
module tb_rs_add_station;

  logic        clk1 = 1'b0;
  logic        rst, flush, iss_valid, iss_ready, iss_rs1b, iss_rs2b;
  logic [15:0] iss_rs1, iss_rs2, cdb_data, disp_a, disp_b;
  logic [2:0]  iss_rob_ind, cdb_tag, disp_rob_ind;
  logic [3:0]  iss_func, disp_func;
  logic        cdb_valid, disp_valid, disp_ready, func_err;
  logic [1:0]  occ;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic [2:0]  r;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  rs_add_station dut (
    .clk1(clk1), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1b(iss_rs1b), .iss_rs1(iss_rs1), .iss_rs2b(iss_rs2b), .iss_rs2(iss_rs2),
    .iss_rob_ind(iss_rob_ind), .iss_func(iss_func),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_a(disp_a), .disp_b(disp_b), .disp_func(disp_func), .disp_rob_ind(disp_rob_ind),
    .occ(occ), .func_err(func_err)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, input logic [2:0] r);
    exp_t e;
    e.a = a; e.b = b; e.f = f; e.r = r;
    sb.push_back(e);
  endtask

  task automatic drive_iss(input logic b1, input logic [15:0] v1, input logic b2,
                           input logic [15:0] v2, input logic [2:0] rob, input logic [3:0] f);
    iss_valid = 1'b1; iss_rs1b = b1; iss_rs1 = v1; iss_rs2b = b2; iss_rs2 = v2;
    iss_rob_ind = rob; iss_func = f;
  endtask

  task automatic drive_cdb(input logic v, input logic [2:0] t, input logic [15:0] d);
    cdb_valid = v; cdb_tag = t; cdb_data = d;
  endtask

  // Compare handshakes against the scoreboard on the falling edge, then advance one cycle.
  task automatic step();
    exp_t e;
    @(negedge clk1);
    if (disp_valid && disp_ready) begin
      check("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("disp_a", 32'(disp_a), 32'(e.a));
        check("disp_b", 32'(disp_b), 32'(e.b));
        check("disp_func", 32'(disp_func), 32'(e.f));
        check("disp_rob", 32'(disp_rob_ind), 32'(e.r));
      end
    end
    @(posedge clk1);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_ready = 1'b0;
    iss_valid = 1'b0; iss_rs1b = 1'b0; iss_rs1 = '0; iss_rs2b = 1'b0; iss_rs2 = '0;
    iss_rob_ind = '0; iss_func = '0;
    drive_cdb(1'b0, 3'd0, 16'h0);
    repeat (2) step();
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_iss_ready", 32'(iss_ready), 32'd1);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_func_err", 32'(func_err), 32'd0);
    check("rst_disp_a", 32'(disp_a), 32'd0);
    check("rst_disp_b", 32'(disp_b), 32'd0);
    rst = 1'b0;
    step();

    // Both operands as values.
    disp_ready = 1'b1;
    drive_iss(1'b1, 16'd5, 1'b1, 16'd7, 3'd2, 4'b0000);
    push_exp(16'd5, 16'd7, 4'b0000, 3'd2);
    step();
    iss_valid = 1'b0;
    check("t1_disp_valid", 32'(disp_valid), 32'd1);
    check("t1_occ", 32'(occ), 32'd1);
    step();
    check("t1_occ_after", 32'(occ), 32'd0);

    // Tag operand resolved by a later CDB broadcast.
    drive_iss(1'b0, 16'd4, 1'b1, 16'd3, 3'd1, 4'b0000);
    push_exp(16'h0010, 16'd3, 4'b0000, 3'd1);
    step();
    iss_valid = 1'b0;
    check("t2_wait", 32'(disp_valid), 32'd0);
    step();
    drive_cdb(1'b1, 3'd4, 16'h0010);
    check("t2_no_comb_path", 32'(disp_valid), 32'd0);
    step();
    drive_cdb(1'b0, 3'd0, 16'h0);
    check("t2_resolved", 32'(disp_valid), 32'd1);
    step();

    // Fill to capacity with the adder stalled.
    disp_ready = 1'b0;
    drive_iss(1'b1, 16'd3, 1'b1, 16'd30, 3'd3, 4'b0000); push_exp(16'd3, 16'd30, 4'b0000, 3'd3); step();
    drive_iss(1'b1, 16'd4, 1'b1, 16'd40, 3'd4, 4'b0001); push_exp(16'd4, 16'd40, 4'b0001, 3'd4); step();
    drive_iss(1'b1, 16'd5, 1'b1, 16'd50, 3'd5, 4'b0000); push_exp(16'd5, 16'd50, 4'b0000, 3'd5); step();
    check("t3_full_occ", 32'(occ), 32'd3);
    check("t3_full_ready", 32'(iss_ready), 32'd0);
    drive_iss(1'b1, 16'd6, 1'b1, 16'd60, 3'd6, 4'b0000);
    step();
    check("t3_4th_ignored", 32'(occ), 32'd3);
    check("t3_held_rob", 32'(disp_rob_ind), 32'd3);
    disp_ready = 1'b1;
    step();
    iss_valid = 1'b0;
    check("t3_bubble_occ", 32'(occ), 32'd2);
    check("t3_release_ready", 32'(iss_ready), 32'd1);
    step();
    step();
    check("t3_drained", 32'(occ), 32'd0);

    // Same-cycle CDB bypass into a newly accepted op.
    drive_iss(1'b1, 16'd9, 1'b0, 16'd6, 3'd6, 4'b0001);
    drive_cdb(1'b1, 3'd6, 16'hABCD);
    push_exp(16'd9, 16'hABCD, 4'b0001, 3'd6);
    step();
    iss_valid = 1'b0;
    drive_cdb(1'b0, 3'd0, 16'h0);
    check("t4_bypass_valid", 32'(disp_valid), 32'd1);
    check("t4_bypass_b", 32'(disp_b), 32'hABCD);
    step();

    // Older late-ready entry in slot 1 against a younger ready entry in slot 0.
    drive_iss(1'b1, 16'd1, 1'b1, 16'd2, 3'd7, 4'b0000);
    push_exp(16'd1, 16'd2, 4'b0000, 3'd7);
    step();
    drive_iss(1'b0, 16'd2, 1'b1, 16'd1, 3'd5, 4'b0000);
    step();
    check("t5_swap_occ", 32'(occ), 32'd1);
    disp_ready = 1'b0;
    drive_iss(1'b1, 16'd4, 1'b1, 16'd4, 3'd3, 4'b0001);
    drive_cdb(1'b1, 3'd2, 16'h0022);
    step();
    iss_valid = 1'b0;
    drive_cdb(1'b0, 3'd0, 16'h0);
    check("t5_occ", 32'(occ), 32'd2);
`ifdef RS_AGE_ORDER_EN
    push_exp(16'h0022, 16'd1, 4'b0000, 3'd5);
    push_exp(16'd4, 16'd4, 4'b0001, 3'd3);
    check("t5_first_pick", 32'(disp_rob_ind), 32'd5);
`else
    push_exp(16'd4, 16'd4, 4'b0001, 3'd3);
    push_exp(16'h0022, 16'd1, 4'b0000, 3'd5);
    check("t5_first_pick", 32'(disp_rob_ind), 32'd3);
`endif
    disp_ready = 1'b1;
    step();
    step();
    check("t5_drained", 32'(occ), 32'd0);

    // Unsupported opcode is dropped with a one-cycle error pulse.
    drive_iss(1'b1, 16'd1, 1'b1, 16'd1, 3'd0, 4'b0010);
    step();
    iss_valid = 1'b0;
    check("t6_func_err", 32'(func_err), 32'd1);
    check("t6_not_stored", 32'(occ), 32'd0);
    step();
    check("t6_pulse_end", 32'(func_err), 32'd0);

    // Flush wins over a simultaneous accept.
    disp_ready = 1'b0;
    drive_iss(1'b1, 16'd11, 1'b1, 16'd12, 3'd1, 4'b0000); step();
    drive_iss(1'b1, 16'd13, 1'b1, 16'd14, 3'd2, 4'b0000); step();
    check("t7_occ", 32'(occ), 32'd2);
    check("t7_valid", 32'(disp_valid), 32'd1);
    drive_iss(1'b1, 16'd15, 1'b1, 16'd16, 3'd4, 4'b0000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    iss_valid = 1'b0;
    check("t7_flush_occ", 32'(occ), 32'd0);
    check("t7_flush_valid", 32'(disp_valid), 32'd0);
    check("t7_flush_ready", 32'(iss_ready), 32'd1);

    // Asynchronous reset mid-run.
    drive_iss(1'b1, 16'd21, 1'b1, 16'd22, 3'd1, 4'b0000); step();
    drive_iss(1'b1, 16'd23, 1'b1, 16'd24, 3'd2, 4'b0001); step();
    iss_valid = 1'b0;
    check("t8_occ_before", 32'(occ), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t8_async_occ", 32'(occ), 32'd0);
    check("t8_async_valid", 32'(disp_valid), 32'd0);
    check("t8_async_ready", 32'(iss_ready), 32'd1);
    rst = 1'b0;
    step();

    // Operation after reset with extreme operand values.
    disp_ready = 1'b1;
    drive_iss(1'b1, 16'hFFFF, 1'b1, 16'h8000, 3'd7, 4'b0001);
    push_exp(16'hFFFF, 16'h8000, 4'b0001, 3'd7);
    step();
    iss_valid = 1'b0;
    step();
    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("end_occ", 32'(occ), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
